// File: rtl/mpu_pkg.sv
// Shared definitions for the matrix multiply unit: default widths, drain FSM states
// and a constant-evaluable clog2 used for index widths.
package mpu_pkg;

    localparam int DEF_VAR_SIZE = 8;
    localparam int DEF_ACC_SIZE = 32;
    localparam int DEF_MMU_SIZE = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/mmu_quant.sv
// Per-element quantizer: optional ReLU, round-half-up arithmetic right shift,
// then saturation of the result to the signed output width.
module mmu_quant import mpu_pkg::*; #(
    parameter int VAR_SIZE = DEF_VAR_SIZE,
    parameter int ACC_SIZE = DEF_ACC_SIZE
) (
    input  logic signed [ACC_SIZE-1:0] x,
    input  logic        [4:0]          shift,
    input  logic                       relu_en,
    output logic signed [VAR_SIZE-1:0] y
);

    localparam logic signed [ACC_SIZE:0] SAT_MAX = (ACC_SIZE+1)'((2 ** (VAR_SIZE - 1)) - 1);
    localparam logic signed [ACC_SIZE:0] SAT_MIN = -(ACC_SIZE+1)'(2 ** (VAR_SIZE - 1));

    // One guard bit keeps x + 2^(shift-1) from overflowing for any input.
    function automatic logic signed [ACC_SIZE:0] round_shr(
        input logic signed [ACC_SIZE-1:0] v,
        input logic        [4:0]          sh
    );
        logic signed [ACC_SIZE:0] ext;
        logic signed [ACC_SIZE:0] bias;
        ext  = {v[ACC_SIZE-1], v};
        bias = '0;
        if (sh != 5'd0) bias[sh - 5'd1] = 1'b1;
        return (ext + bias) >>> sh;
    endfunction

    function automatic logic signed [VAR_SIZE-1:0] saturate(input logic signed [ACC_SIZE:0] r);
        logic signed [ACC_SIZE:0] c;
        if (r > SAT_MAX)      c = SAT_MAX;
        else if (r < SAT_MIN) c = SAT_MIN;
        else                  c = r;
        return c[VAR_SIZE-1:0];
    endfunction

    logic signed [ACC_SIZE-1:0] x_relu;

    assign x_relu = (relu_en && x < 0) ? '0 : x;
    assign y      = saturate(round_shr(x_relu, shift));

endmodule

// File: rtl/mmu_drain.sv
// Result-drain stage: captures one packed MMU result tile, then streams quantized
// elements out one per beat in row-major order over valid/ready.
module mmu_drain import mpu_pkg::*; #(
    parameter int VAR_SIZE = DEF_VAR_SIZE,
    parameter int ACC_SIZE = DEF_ACC_SIZE,
    parameter int MMU_SIZE = DEF_MMU_SIZE
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [ACC_SIZE*MMU_SIZE*MMU_SIZE-1:0]      C1,
    input  logic                                       c_valid,
    output logic                                       c_ready,
    input  logic [4:0]                                 shift,
    input  logic                                       relu_en,
    output logic signed [VAR_SIZE-1:0]                 out_data,
    output logic [clog2(MMU_SIZE*MMU_SIZE)-1:0]        out_idx,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       out_last
);

    localparam int NELEM = MMU_SIZE * MMU_SIZE;
    localparam int IDX_W = clog2(NELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NELEM - 1);

    state_e                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic signed [ACC_SIZE-1:0] tile_q [NELEM];
    logic [4:0]                 shift_q;
    logic                       relu_q;
    logic signed [VAR_SIZE-1:0] q_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            for (int i = 0; i < NELEM; i++) tile_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (c_valid) begin
                        for (int i = 0; i < NELEM; i++) tile_q[i] <= C1[i*ACC_SIZE +: ACC_SIZE];
                        shift_q <= shift;
                        relu_q  <= relu_en;
                        idx_q   <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // All outputs derive from registered state, so nothing from C1 or out_ready leaks through.
    mmu_quant #(
        .VAR_SIZE (VAR_SIZE),
        .ACC_SIZE (ACC_SIZE)
    ) u_quant (
        .x       (tile_q[idx_q]),
        .shift   (shift_q),
        .relu_en (relu_q),
        .y       (q_data)
    );

    assign c_ready   = (state_q == IDLE);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign out_data  = out_valid ? q_data : '0;
    assign out_idx   = idx_q;

endmodule

// File: doc/mmu_drain.md
# mmu_drain

Result-drain stage for the matrix multiply unit. It captures one packed tile of `MMU_SIZE`×`MMU_SIZE` signed `ACC_SIZE` accumulator results, applies optional ReLU, applies a rounding right shift, and saturates each element to `VAR_SIZE`. It then streams the elements out one per beat, in row-major order, over a valid/ready interface. It sits between the MMU result port and the write-back/activation buffer, and is the consumer end of the packed `C1` result bus.

## Interface
- `VAR_SIZE`, 8, output element width (signed)
- `ACC_SIZE`, 32, accumulator element width (signed)
- `MMU_SIZE`, 4, tile dimension; the tile holds `MMU_SIZE*MMU_SIZE` elements
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low. This is decided.
- `C1` in `ACC_SIZE*MMU_SIZE*MMU_SIZE`: packed tile. Element (row d, col e) is at `C1[(d*MMU_SIZE+e)*ACC_SIZE +: ACC_SIZE]`.
- `c_valid` in 1: `C1`, `shift` and `relu_en` are valid.
- `c_ready` out 1: the block can capture a tile.
- `shift` in 5: arithmetic right-shift amount, 0..31.
- `relu_en` in 1: clamp negative elements to 0 before shifting.
- `out_data` out `VAR_SIZE`: quantized element, signed.
- `out_idx` out `clog2(MMU_SIZE*MMU_SIZE)`: flat index of `out_data`, equal to d*MMU_SIZE+e.
- `out_valid` out 1: `out_data`, `out_idx` and `out_last` are valid.
- `out_ready` in 1: the downstream stage accepts the beat.
- `out_last` out 1: marks the final element of the tile.

## Operation
- The block has two states, IDLE and DRAIN.
- `c_ready` = (state == IDLE). There is no overlap between the capture handshake and draining.
- **IDLE:**
  - On `c_valid && c_ready`, register the whole `C1` tile, `shift` and `relu_en`.
  - Set idx = 0 and go to DRAIN.
- **DRAIN:**
  - `out_valid` = 1.
  - `out_data` = quant(tile[idx]).
  - `out_last` = (idx == MMU_SIZE²−1).
  - On `out_valid && out_ready`: if `out_last`, go to IDLE; otherwise idx += 1.
- quant(x):
  - If `relu_en` and x < 0, set x = 0.
  - Compute r = (x + (shift != 0 ? 2^(shift−1) : 0)) >>> shift in `ACC_SIZE`+1 bits. This is round-half-up (toward +∞) and cannot overflow.
  - Saturate r to [−2^(VAR_SIZE−1), 2^(VAR_SIZE−1)−1].
- `shift` and `relu_en` are sampled only at capture. Changes to them during DRAIN have no effect.
- `c_valid` during DRAIN is ignored. The upstream stage holds its data until `c_ready` is high.
- While `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` hold stable.
- Reset (asynchronous, any time, including mid-drain):
  - state = IDLE, idx = 0, and the tile register and captured config are cleared to 0.
  - Outputs: `out_valid` = 0, `out_last` = 0, `out_data` = 0, `out_idx` = 0, `c_ready` = 1.
  - A partially drained tile is discarded.

## Timing
- Capture at edge T gives `out_valid` = 1 after T. The first element is presented in the cycle following capture.
- Full throughput with `out_ready` held at 1: one element per cycle.
- The last beat is accepted at edge L. `c_ready` = 1 after L, and the next capture can happen at edge L+1.
- Tile period with no backpressure is MMU_SIZE²+1 cycles.
- `out_data` is combinational from registered state only. There is no combinational path from `C1`, `c_valid` or `out_ready` to any output.
- The `out_ready` → `c_ready` dependency is through a register only.

## Structure
- Shared package `mpu_pkg` holds:
  - the state enum (IDLE, DRAIN);
  - the default widths (VAR_SIZE, ACC_SIZE, MMU_SIZE);
  - a `clog2` function, used for the idx width.
- Sub-module `mmu_quant`: combinational per-element ReLU, rounding shift and saturation, parameterized by VAR_SIZE and ACC_SIZE. It is instantiated once and fed by the idx-selected tile element.
- The top level holds the FSM, the idx counter, the tile register and the captured config.

## Test plan
All scenarios use VAR_SIZE=8, ACC_SIZE=32, MMU_SIZE=4.
1. **Reset values:** hold `rst_n` low mid-simulation -> `out_valid`=0, `out_last`=0, `out_data`=0, `c_ready`=1 immediately, with no clock edge needed.
2. **Pass-through:** element f = f for f = 0..15, `shift`=0, relu off, `out_ready`=1 -> 16 consecutive beats with data 0..15 and `out_idx` 0..15. `out_last` is set only on beat 16. `c_ready` returns to 1 the cycle after beat 16.
3. **Rounding, `shift` = 1:** elements 5, −5, 6, −6 -> outputs 3, −2, 3, −3.
4. **Rounding, `shift` = 2:** element 6 -> output 2.
5. **Saturation and ReLU:**
   - Elements 1000, −1000, 127, −129 with relu off -> 127, −128, 127, −128.
   - The same elements with relu on -> 127, 0, 127, 0.
6. **Backpressure and ignored inputs:**
   - Toggle `out_ready` 1/0 every cycle -> data is held while stalled, no element is skipped or repeated, and exactly 16 beats are accepted.
   - Pulse `c_valid` and change `shift` during drain -> no capture occurs and the output is unaffected.
7. **Reset mid-drain:**
   - Assert `rst_n` low after 5 accepted beats -> `out_valid` drops asynchronously.
   - After release, capture a new tile -> it drains from `out_idx` 0 and contains only new-tile values.
